wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the five-stage core. Consumes the registered outputs of the EX/WB pipeline buffer (`out_regWrite`, `out_WAI`, `out_memRead`, `out_PC`, `out_readData`, `out_ALUResult`, `out_rd`) and selects the writeback value. Commits that value to a 64 x 32 register file and serves the two combinational read ports used by instruction decode. Also holds a one-entry last-write record for EX forwarding and a retired-write counter for debug.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- ADDR_W, 6, register address width
- NREG, 64, register count (2**ADDR_W)

Ports:
- clock  in  1  single core clock
- reset  in  1  reset; one clock, synchronous, active-high
- regWrite  in  1  commit enable from EX/WB buffer
- WAI  in  1  writeback source is PC
- memRead  in  1  writeback source is readData
- PC  in  DATA_W  PC of the committing instruction
- readData  in  DATA_W  data-memory load result
- ALUResult  in  DATA_W  ALU result
- rd  in  ADDR_W  destination register
- rs, rt  in  ADDR_W  decode read addresses
- rs_data, rt_data  out  DATA_W  read-port data, combinational
- wb_data  out  DATA_W  selected writeback value, combinational
- fwd_valid  out  1  last_rd/last_data hold a committed write
- fwd_rd  out  ADDR_W  destination of most recent commit
- fwd_data  out  DATA_W  value of most recent commit
- retired  out  32  count of commits since reset, saturating

## Operation
- Source select, fixed priority:
  - WAI=1 → PC.
  - Else memRead=1 → readData.
  - Else ALUResult.
  - WAI and memRead both 1: PC wins.
- Commit:
  - On the rising clock edge with regWrite=1 and reset=0, `regs[rd] <= wb_data`.
  - All 64 registers are writable; no hardwired zero.
- Read ports:
  - `rs_data = regs[rs]`, `rt_data = regs[rt]`.
  - Write-through bypass: when regWrite=1 and rd==rs, rs_data = wb_data in the same cycle. Same rule for rt.
  - Both ports may address the same register or rd simultaneously; both bypass.
- Forward record:
  - On a commit, update fwd_rd <= rd, fwd_data <= wb_data, fwd_valid <= 1.
  - With no commit, hold the record unchanged.
- Retired counter:
  - Increment by 1 on each commit.
  - Holds at 32'hFFFF_FFFF; no wrap-around.
- Inputs with regWrite=0 have no state effect, regardless of the other input values.

## Timing
- The EX/WB buffer updates on the falling edge. This block's inputs are therefore stable for the half-cycle before each rising edge; all state in this block updates on the rising edge.
- Latency:
  - Combinational outputs (wb_data, rs_data, rt_data): 0 cycles.
  - Register contents, fwd_*, retired: visible 1 cycle after the commit edge. Reads of the same register before that edge are covered by the bypass.
- Reset:
  - Synchronous; takes effect at the rising edge while reset=1.
  - Clears all registers, fwd_valid, fwd_rd, fwd_data and retired to 0.
  - Reset dominates a simultaneous commit: the write is dropped and the counter is not incremented.
  - While reset is held, rs_data and rt_data still show the combinational bypass when regWrite=1.
  - After release, the first commit happens at the first rising edge with reset=0.
- Back-to-back commits to the same rd: last writer wins. fwd_* tracks each commit.

## Structure
- Shared package `core_pkg`:
  - DATA_W, ADDR_W, NREG.
  - Writeback-source enum WB_PC / WB_MEM / WB_ALU.
  - RETIRED_MAX constant.
- Sub-module `regfile_64x32`: storage array, synchronous reset, write port, two read ports with write-through bypass.
- Top level contains the source-select mux, forward record and counter.

## Test plan
- Reset, then read all 64 addresses → every rs_data/rt_data = 0; retired=0; fwd_valid=0.
- Commit ALUResult=32'h1234 to rd=5 (WAI=0, memRead=0), rs=5 in the same cycle → rs_data=32'h1234 before the edge (bypass). After the edge: regs[5]=32'h1234, fwd_rd=5, retired=1.
- WAI=1, memRead=1, PC=32'h40, readData=32'hDEAD, rd=63 → wb_data=32'h40. Register 63 reads 32'h40 next cycle.
- regWrite=0 with rd=7, ALUResult=32'hFF → regs[7] stays 0; fwd_* and retired unchanged.
- Commit 32'hAA to rd=9 on the same edge as reset=1 → regs[9]=0, retired=0, fwd_valid=0.
- Force retired to 32'hFFFF_FFFE, then two commits → 32'hFFFF_FFFF, and it holds there.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants, writeback-source encoding and the source-select helper.
package core_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned NREG   = 64;

  localparam logic [31:0] RETIRED_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    WB_PC  = 2'd0,
    WB_MEM = 2'd1,
    WB_ALU = 2'd2
  } wb_src_e;

  // PC outranks load data, which outranks the ALU result
  function automatic wb_src_e wb_source(input logic wai, input logic mem_read);
    if (wai)           return WB_PC;
    else if (mem_read) return WB_MEM;
    else               return WB_ALU;
  endfunction

endpackage

// File: rtl/regfile_64x32.sv
// Architectural register storage: synchronous clear, one write port, two
// combinational read ports with write-through bypass of the pending write.
module regfile_64x32
  import core_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned AW = ADDR_W,
  parameter int unsigned NR = NREG
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1
);

  logic [DW-1:0] regs [NR];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NR); i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  // Bypass is independent of reset so decode sees the in-flight value
  always_comb begin
    rd0 = regs[ra0];
    rd1 = regs[ra1];
    if (we && (wa == ra0)) rd0 = wd;
    if (we && (wa == ra1)) rd1 = wd;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the commit value, writes the register file and
// tracks the last-write forward record plus a saturating retired count.
module wb_regfile
  import core_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              regWrite,
  input  logic              WAI,
  input  logic              memRead,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] readData,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retired
);

  wb_src_e wb_src;

  always_comb begin
    wb_src  = wb_source(WAI, memRead);
    wb_data = ALUResult;
    case (wb_src)
      WB_PC:   wb_data = PC;
      WB_MEM:  wb_data = readData;
      WB_ALU:  wb_data = ALUResult;
      default: wb_data = ALUResult;
    endcase
  end

  regfile_64x32 #(
    .DW(DATA_W),
    .AW(ADDR_W),
    .NR(NREG)
  ) u_regs (
    .clock(clock),
    .reset(reset),
    .we   (regWrite),
    .wa   (rd),
    .wd   (wb_data),
    .ra0  (rs),
    .ra1  (rt),
    .rd0  (rs_data),
    .rd1  (rt_data)
  );

  // Forward record and retired counter; reset drops a coincident commit
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_rd    <= '0;
      fwd_data  <= '0;
      retired   <= '0;
    end else if (regWrite) begin
      fwd_valid <= 1'b1;
      fwd_rd    <= rd;
      fwd_data  <= wb_data;
      if (retired != RETIRED_MAX) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Randomised bench for wb_regfile: a plain array/counter model predicts every
// output each cycle, with directed literal checks pinning the model.
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset, regWrite, WAI, memRead;
  logic [31:0] PC, readData, ALUResult;
  logic [5:0]  rd, rs, rt;
  logic [31:0] rs_data, rt_data, wb_data, fwd_data, retired;
  logic        fwd_valid;
  logic [5:0]  fwd_rd;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          check_en = 1'b0;

  logic [31:0] m_regs [64];
  logic        m_fv;
  logic [5:0]  m_frd;
  logic [31:0] m_fd;
  logic [31:0] m_ret;

  wb_regfile dut (
    .clock(clock), .reset(reset), .regWrite(regWrite), .WAI(WAI),
    .memRead(memRead), .PC(PC), .readData(readData), .ALUResult(ALUResult),
    .rd(rd), .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .retired(retired)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_wb();
    if (WAI) return PC;
    if (memRead) return readData;
    return ALUResult;
  endfunction

  function automatic logic [31:0] exp_read(input logic [5:0] a);
    if (regWrite && rd == a) return exp_wb();
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model advances on every rising edge
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) m_regs[i] = 32'd0;
      m_fv = 1'b0; m_frd = 6'd0; m_fd = 32'd0; m_ret = 32'd0;
    end else if (regWrite) begin
      m_regs[rd] = exp_wb();
      m_fv = 1'b1; m_frd = rd; m_fd = exp_wb();
      if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 32'd1;
    end
  end

  // Per-cycle comparison in the stable window before the rising edge
  always @(negedge clock) begin
    #4;
    if (check_en) begin
      chk("wb_data",   wb_data,          exp_wb());
      chk("rs_data",   rs_data,          exp_read(rs));
      chk("rt_data",   rt_data,          exp_read(rt));
      chk("fwd_valid", 32'(fwd_valid),   32'(m_fv));
      chk("fwd_rd",    32'(fwd_rd),      32'(m_frd));
      chk("fwd_data",  fwd_data,         m_fd);
      chk("retired",   retired,          m_ret);
    end
  end

  task automatic drive(input logic rst, input logic we, input logic wai, input logic mr,
                       input logic [31:0] pc, input logic [31:0] rdat, input logic [31:0] alu,
                       input logic [5:0] d, input logic [5:0] s, input logic [5:0] t);
    @(negedge clock);
    reset = rst; regWrite = we; WAI = wai; memRead = mr;
    PC = pc; readData = rdat; ALUResult = alu; rd = d; rs = s; rt = t;
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; WAI = 1'b0; memRead = 1'b0;
    PC = '0; readData = '0; ALUResult = '0; rd = '0; rs = '0; rt = '0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_en = 1'b1;

    // Every address reads zero after reset
    for (int i = 0; i < 64; i++) begin
      drive(0, 0, 0, 0, 32'h1, 32'h2, 32'h3, 6'(i), 6'(i), 6'(63 - i));
      #4;
      chk("reset_rs", rs_data, 32'd0);
      chk("reset_rt", rt_data, 32'd0);
    end
    chk("reset_retired", retired, 32'd0);
    chk("reset_fwd_valid", 32'(fwd_valid), 32'd0);

    // ALU commit with same-cycle bypass
    drive(0, 1, 0, 0, 32'h0, 32'h0, 32'h1234, 6'd5, 6'd5, 6'd0);
    #4 chk("bypass_rs5", rs_data, 32'h1234);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd5, 6'd0);
    #4;
    chk("reg5", rs_data, 32'h1234);
    chk("fwd_rd5", 32'(fwd_rd), 32'd5);
    chk("retired1", retired, 32'd1);

    // PC outranks readData
    drive(0, 1, 1, 1, 32'h40, 32'hDEAD, 32'h77, 6'd63, 6'd0, 6'd0);
    #4 chk("wb_pc_prio", wb_data, 32'h40);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0, 6'd63);
    #4 chk("reg63", rt_data, 32'h40);

    // regWrite low leaves state alone
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'hFF, 6'd7, 6'd7, 6'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd7, 6'd0);
    #4;
    chk("reg7_untouched", rs_data, 32'd0);
    chk("retired_hold", retired, 32'd2);
    chk("fwd_rd_hold", 32'(fwd_rd), 32'd63);
    chk("fwd_data_hold", fwd_data, 32'h40);

    // Reset dominates a coincident commit, but the bypass still shows
    drive(1, 1, 0, 0, 32'h0, 32'h0, 32'hAA, 6'd9, 6'd9, 6'd0);
    #4 chk("bypass_in_reset", rs_data, 32'hAA);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd9, 6'd0);
    #4;
    chk("reg9_dropped", rs_data, 32'd0);
    chk("retired_rst", retired, 32'd0);
    chk("fwd_valid_rst", 32'(fwd_valid), 32'd0);

    // Random traffic with bypass-heavy addressing and rare resets
    for (int n = 0; n < 2000; n++) begin
      logic [5:0] d;
      d = 6'($urandom_range(0, 63));
      drive(($urandom % 64) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
            $urandom, $urandom, $urandom, d,
            (($urandom % 3) == 0) ? d : 6'($urandom_range(0, 63)),
            (($urandom % 3) == 0) ? d : 6'($urandom_range(0, 63)));
    end

    // Saturation: preload counter near the top
    @(negedge clock);
    reset = 1'b0; regWrite = 1'b0;
    force dut.retired = 32'hFFFF_FFFE;
    m_ret = 32'hFFFF_FFFE;
    #1 release dut.retired;
    for (int n = 0; n < 3; n++) drive(0, 1, 0, 0, 32'h0, 32'h0, 32'(n), 6'(n), 6'd0, 6'd0);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0, 6'd0);
    #4 chk("retired_sat", retired, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0, 6'd0);

    #2;
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
